// File: rtl/sram_access_scheduler.sv
// ---------------------------------------------------------------------------
// sram_access_scheduler
//
// Owns both ports of the dual-port frame SRAM and decides who drives them.
//
// In normal operation (RUN):
//   - port A is shared round-robin between the event writer (ev_*) and
//     the host (h_*). Grants are combinational in the request cycle.
//   - port B is dedicated to the readout streamer (rd_*), which only reads.
//
// On reset, or when clear_start is seen in RUN, both ports are handed to
// the external SRAM clear engine (rs_*). The block waits for the engine's
// done interrupt, acknowledges it and then returns to RUN.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   clear_start            clear request, honoured only in RUN
//   clr_busy               high while any clear state is active
//   clear_done             one-cycle pulse on return to RUN
//   rs_enable, rs_ack      clear engine start pulse / interrupt acknowledge
//   rs_irq                 clear engine done interrupt (level)
//   rs_ce_x, rs_addr_x     clear engine port controls, x in {a,b}
//   ev_req/addr/wdata/gnt  event writer (port A, write only)
//   h_req/we/addr/wdata/wmask/gnt, h_rdata/h_rvalid
//                          host (port A, read or masked write)
//   rd_req/addr/gnt, rd_rdata/rd_rvalid
//                          readout streamer (port B, read only)
//   mem_*_a, mem_*_b       SRAM macro port signals
//
// Read data comes straight from the macro, which has one cycle of read
// latency, so the rvalid flags are the grants delayed by one cycle.
// ---------------------------------------------------------------------------
module sram_access_scheduler #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int MW = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             clear_start,
  output logic             clr_busy,
  output logic             clear_done,

  output logic             rs_enable,
  output logic             rs_ack,
  input  logic             rs_irq,
  input  logic             rs_ce_a,
  input  logic             rs_ce_b,
  input  logic [AW-1:0]    rs_addr_a,
  input  logic [AW-1:0]    rs_addr_b,

  input  logic             ev_req,
  input  logic [AW-1:0]    ev_addr,
  input  logic [WIDTH-1:0] ev_wdata,
  output logic             ev_gnt,

  input  logic             h_req,
  input  logic             h_we,
  input  logic [AW-1:0]    h_addr,
  input  logic [WIDTH-1:0] h_wdata,
  input  logic [MW-1:0]    h_wmask,
  output logic             h_gnt,
  output logic [WIDTH-1:0] h_rdata,
  output logic             h_rvalid,

  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic [WIDTH-1:0] rd_rdata,
  output logic             rd_rvalid,

  output logic             mem_ce_a,
  output logic             mem_we_a,
  output logic [AW-1:0]    mem_addr_a,
  output logic [WIDTH-1:0] mem_wdata_a,
  output logic [MW-1:0]    mem_wmask_a,
  input  logic [WIDTH-1:0] mem_rdata_a,

  output logic             mem_ce_b,
  output logic             mem_we_b,
  output logic [AW-1:0]    mem_addr_b,
  output logic [WIDTH-1:0] mem_wdata_b,
  output logic [MW-1:0]    mem_wmask_b,
  input  logic [WIDTH-1:0] mem_rdata_b
);

  // FSM encoding
  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] CLR_START = 2'd1;
  localparam logic [1:0] CLR_BUSY  = 2'd2;
  localparam logic [1:0] CLR_DONE  = 2'd3;

  // Identity of the most recent port A winner
  localparam logic WIN_EV   = 1'b0;
  localparam logic WIN_HOST = 1'b1;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_win;
  logic       last_win_next;
  logic       h_rvalid_q;
  logic       rd_rvalid_q;

  logic       grant_ok;
  logic       clr_drive;

  // Grants only in RUN, and never in the cycle that leaves RUN for a clear.
  // rst gates everything so outputs are quiet while reset is held.
  assign grant_ok  = (state == RUN) && !clear_start && !rst;
  assign clr_drive = (state == CLR_BUSY) && !rst;

  // Port A arbitration: a lone requester always wins; under contention the
  // client that did not win last time gets the port, so the two alternate.
  always_comb begin
    ev_gnt = 1'b0;
    h_gnt  = 1'b0;
    if (grant_ok) begin
      if (ev_req && h_req) begin
        if (last_win == WIN_HOST) begin
          ev_gnt = 1'b1;
        end else begin
          h_gnt = 1'b1;
        end
      end else begin
        ev_gnt = ev_req;
        h_gnt  = h_req;
      end
    end
  end

  assign rd_gnt = grant_ok && rd_req;

  // Round-robin history follows every grant, contended or not.
  always_comb begin
    last_win_next = last_win;
    if (ev_gnt) begin
      last_win_next = WIN_EV;
    end else if (h_gnt) begin
      last_win_next = WIN_HOST;
    end
  end

  // Clear sequencing: kick the engine, wait for its interrupt, then spend
  // one cycle in CLR_DONE to signal completion before returning to RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:       if (clear_start) state_next = CLR_START;
      CLR_START: state_next = CLR_BUSY;
      CLR_BUSY:  if (rs_irq) state_next = CLR_DONE;
      CLR_DONE:  state_next = RUN;
      default:   state_next = CLR_START;
    endcase
  end

  // State, arbitration history and read-valid pipeline. Reset forces a
  // clear so the frame memory is zeroed at boot, and discards any read
  // that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLR_START;
      last_win    <= WIN_HOST;
      h_rvalid_q  <= 1'b0;
      rd_rvalid_q <= 1'b0;
    end else begin
      state       <= state_next;
      last_win    <= last_win_next;
      h_rvalid_q  <= h_gnt && !h_we;
      rd_rvalid_q <= rd_gnt;
    end
  end

  // Status and clear-engine handshake. rs_ack is combinational with rs_irq
  // so the engine sees the acknowledge in the cycle it raises the interrupt.
  assign clr_busy   = rst || (state != RUN);
  assign rs_enable  = !rst && (state == CLR_START);
  assign rs_ack     = clr_drive && rs_irq;
  assign clear_done = !rst && (state == CLR_DONE);

  // Read data passes straight through from the macro; only the valid
  // strobes are registered.
  assign h_rvalid  = h_rvalid_q && !rst;
  assign rd_rvalid = rd_rvalid_q && !rst;
  assign h_rdata   = mem_rdata_a;
  assign rd_rdata  = mem_rdata_b;

  // Port A driver: clear engine while clearing, otherwise the granted
  // client. Event writes are always full-word writes.
  always_comb begin
    mem_ce_a    = 1'b0;
    mem_we_a    = 1'b0;
    mem_addr_a  = '0;
    mem_wdata_a = '0;
    mem_wmask_a = '0;
    if (clr_drive) begin
      mem_ce_a    = rs_ce_a;
      mem_we_a    = 1'b1;
      mem_addr_a  = rs_addr_a;
      mem_wdata_a = '0;
      mem_wmask_a = '1;
    end else if (ev_gnt) begin
      mem_ce_a    = 1'b1;
      mem_we_a    = 1'b1;
      mem_addr_a  = ev_addr;
      mem_wdata_a = ev_wdata;
      mem_wmask_a = '1;
    end else if (h_gnt) begin
      mem_ce_a    = 1'b1;
      mem_we_a    = h_we;
      mem_addr_a  = h_addr;
      mem_wdata_a = h_wdata;
      mem_wmask_a = h_wmask;
    end
  end

  // Port B driver: clear engine while clearing, otherwise readout reads.
  always_comb begin
    mem_ce_b    = 1'b0;
    mem_we_b    = 1'b0;
    mem_addr_b  = '0;
    mem_wdata_b = '0;
    mem_wmask_b = '0;
    if (clr_drive) begin
      mem_ce_b    = rs_ce_b;
      mem_we_b    = 1'b1;
      mem_addr_b  = rs_addr_b;
      mem_wdata_b = '0;
      mem_wmask_b = '1;
    end else if (rd_gnt) begin
      mem_ce_b    = 1'b1;
      mem_we_b    = 1'b0;
      mem_addr_b  = rd_addr;
    end
  end

endmodule

// File: tb/tb_sram_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sram_access_scheduler
//
// Drives directed cycles into sram_access_scheduler, with a behavioural
// read-first dual-port SRAM and a scripted clear engine around it.
// Each stimulus cycle queues the expected control outputs for that cycle;
// expected read data is queued when the read is issued. A monitor on the
// falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_sram_access_scheduler;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int MW    = 4;

  // Expected-vector bit positions: {ev,h,rd,hv,rv,busy,en,ack,done}
  localparam logic [8:0] V_EV   = 9'h100;
  localparam logic [8:0] V_H    = 9'h080;
  localparam logic [8:0] V_RD   = 9'h040;
  localparam logic [8:0] V_HV   = 9'h020;
  localparam logic [8:0] V_RV   = 9'h010;
  localparam logic [8:0] V_BUSY = 9'h008;
  localparam logic [8:0] V_EN   = 9'h004;
  localparam logic [8:0] V_ACK  = 9'h002;
  localparam logic [8:0] V_DONE = 9'h001;
  localparam logic [8:0] V_NONE = 9'h000;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_start;
  logic             clr_busy, clear_done, rs_enable, rs_ack;
  logic             rs_irq, rs_ce_a, rs_ce_b;
  logic [AW-1:0]    rs_addr_a, rs_addr_b;
  logic             ev_req;
  logic [AW-1:0]    ev_addr;
  logic [WIDTH-1:0] ev_wdata;
  logic             ev_gnt;
  logic             h_req, h_we;
  logic [AW-1:0]    h_addr;
  logic [WIDTH-1:0] h_wdata;
  logic [MW-1:0]    h_wmask;
  logic             h_gnt, h_rvalid;
  logic [WIDTH-1:0] h_rdata;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_gnt, rd_rvalid;
  logic [WIDTH-1:0] rd_rdata;
  logic             mem_ce_a, mem_we_a, mem_ce_b, mem_we_b;
  logic [AW-1:0]    mem_addr_a, mem_addr_b;
  logic [WIDTH-1:0] mem_wdata_a, mem_wdata_b;
  logic [MW-1:0]    mem_wmask_a, mem_wmask_b;
  logic [WIDTH-1:0] mem_rdata_a, mem_rdata_b;

  typedef struct {
    string      name;
    logic [8:0] vec;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] hq[$];
  logic [WIDTH-1:0] rq[$];
  int               total = 0;
  int               bad   = 0;

  logic [WIDTH-1:0] mem [DEPTH];

  sram_access_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clr_busy(clr_busy), .clear_done(clear_done),
    .rs_enable(rs_enable), .rs_ack(rs_ack), .rs_irq(rs_irq),
    .rs_ce_a(rs_ce_a), .rs_ce_b(rs_ce_b),
    .rs_addr_a(rs_addr_a), .rs_addr_b(rs_addr_b),
    .ev_req(ev_req), .ev_addr(ev_addr), .ev_wdata(ev_wdata), .ev_gnt(ev_gnt),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_wmask(h_wmask), .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
    .mem_ce_a(mem_ce_a), .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a),
    .mem_wdata_a(mem_wdata_a), .mem_wmask_a(mem_wmask_a),
    .mem_rdata_a(mem_rdata_a),
    .mem_ce_b(mem_ce_b), .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b),
    .mem_wdata_b(mem_wdata_b), .mem_wmask_b(mem_wmask_b),
    .mem_rdata_b(mem_rdata_b)
  );

  always #5 clk = ~clk;

  // Read-first dual-port SRAM with byte-masked writes. Memory starts as
  // all ones so that only a working boot clear produces zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
  end

  always @(posedge clk) begin
    if (mem_ce_a) begin
      mem_rdata_a <= mem[mem_addr_a];
      if (mem_we_a)
        for (int b = 0; b < MW; b++)
          if (mem_wmask_a[b]) mem[mem_addr_a][8*b +: 8] <= mem_wdata_a[8*b +: 8];
    end
    if (mem_ce_b) begin
      mem_rdata_b <= mem[mem_addr_b];
      if (mem_we_b)
        for (int b = 0; b < MW; b++)
          if (mem_wmask_b[b]) mem[mem_addr_b][8*b +: 8] <= mem_wdata_b[8*b +: 8];
    end
  end

  // Queue one cycle's expected outputs, then advance to just after the
  // next rising edge.
  task automatic applyStimulus(input string name, input logic [8:0] vec);
    exp_t e;
    e.name = name;
    e.vec  = vec;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Compare the current cycle's controls and any returned read data.
  task automatic checkOutput();
    exp_t             e;
    logic [8:0]       act;
    logic [WIDTH-1:0] want;
    act = {ev_gnt, h_gnt, rd_gnt, h_rvalid, rd_rvalid,
           clr_busy, rs_enable, rs_ack, clear_done};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e.vec) begin
        bad++;
        $display("[TB] FAIL %s: got {ev,h,rd,hv,rv,busy,en,ack,done}=%b want=%b",
                 e.name, act, e.vec);
      end
    end
    if (h_rvalid === 1'b1) begin
      total++;
      if (hq.size() == 0) begin
        bad++;
        $display("[TB] FAIL h_rdata: unexpected h_rvalid, data=%h", h_rdata);
      end else begin
        want = hq.pop_front();
        if (h_rdata !== want) begin
          bad++;
          $display("[TB] FAIL h_rdata: got=%h want=%h", h_rdata, want);
        end
      end
    end
    if (rd_rvalid === 1'b1) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("[TB] FAIL rd_rdata: unexpected rd_rvalid, data=%h", rd_rdata);
      end else begin
        want = rq.pop_front();
        if (rd_rdata !== want) begin
          bad++;
          $display("[TB] FAIL rd_rdata: got=%h want=%h", rd_rdata, want);
        end
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  // Scripted clear engine: n busy cycles sweeping both ports, then the
  // interrupt (acknowledged the same cycle) and the CLR_DONE cycle.
  // With poke set, clear_start is raised mid-clear and must be ignored.
  task automatic clearEngine(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      rs_ce_a     = 1'b1;
      rs_addr_a   = AW'(i);
      rs_ce_b     = 1'b1;
      rs_addr_b   = AW'(DEPTH - 1 - i);
      clear_start = poke && (i == 1);
      applyStimulus("clr_busy", V_BUSY);
    end
    rs_ce_a     = 1'b0;
    rs_ce_b     = 1'b0;
    clear_start = 1'b0;
    rs_irq      = 1'b1;
    applyStimulus("clr_ack", V_BUSY | V_ACK);
    rs_irq = 1'b0;
    applyStimulus("clr_done", V_BUSY | V_DONE);
  endtask

  // Time limit so a broken run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; clear_start = 1'b0; rs_irq = 1'b0;
    rs_ce_a = 1'b0; rs_ce_b = 1'b0; rs_addr_a = '0; rs_addr_b = '0;
    ev_req = 1'b0; ev_addr = '0; ev_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_wmask = '0;
    rd_req = 1'b0; rd_addr = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles with clients requesting: quiet, busy.
    ev_req = 1'b1; ev_addr = 4'd1; ev_wdata = 32'h1111_1111;
    h_req = 1'b1; h_we = 1'b1; h_addr = 4'd2; h_wdata = 32'hA5A5_A5A5;
    h_wmask = 4'hF;
    applyStimulus("reset0", V_BUSY);
    applyStimulus("reset1", V_BUSY);

    // Boot clear of the whole memory; requests stay up but see no grants.
    rst = 1'b0;
    applyStimulus("boot_start", V_BUSY | V_EN);
    clearEngine(DEPTH, 1'b0);

    // Contention on port A alternates, starting with EV.
    applyStimulus("rr0_ev", V_EV);
    applyStimulus("rr1_h",  V_H);
    applyStimulus("rr2_ev", V_EV);
    applyStimulus("rr3_h",  V_H);
    applyStimulus("rr4_ev", V_EV);
    applyStimulus("rr5_h",  V_H);

    // Host reads back what each client wrote.
    ev_req = 1'b0;
    h_we = 1'b0; h_addr = 4'd1;
    hq.push_back(32'h1111_1111);
    applyStimulus("h_rd1", V_H);
    h_addr = 4'd2;
    hq.push_back(32'hA5A5_A5A5);
    applyStimulus("h_rd2", V_H | V_HV);

    // Masked host write over a cleared word, then read it back.
    h_we = 1'b1; h_addr = 4'd3; h_wdata = 32'hDEAD_BEEF; h_wmask = 4'b0101;
    applyStimulus("h_wr3", V_H | V_HV);
    h_we = 1'b0;
    hq.push_back(32'h00AD_00EF);
    applyStimulus("h_rd3", V_H);

    // EV seeds address 5, then writes it again while readout reads it.
    h_req = 1'b0;
    ev_req = 1'b1; ev_addr = 4'd5; ev_wdata = 32'h1234_5678;
    applyStimulus("ev_wr5", V_EV | V_HV);
    ev_wdata = 32'hCAFE_F00D;
    rd_req = 1'b1; rd_addr = 4'd5;
    rq.push_back(32'h1234_5678);
    applyStimulus("ev_rd_same", V_EV | V_RD);

    // Readout again; an interrupt in RUN must not be acknowledged.
    ev_req = 1'b0; rs_irq = 1'b1;
    rq.push_back(32'hCAFE_F00D);
    applyStimulus("rd5_irq_run", V_RD | V_RV);

    // Clear request: no grants in the transition cycle, rvalid still lands.
    rs_irq = 1'b0; rd_req = 1'b0;
    ev_req = 1'b1; h_req = 1'b1; clear_start = 1'b1;
    applyStimulus("clr_req", V_RV);
    clear_start = 1'b0; ev_req = 1'b0; h_req = 1'b0;
    applyStimulus("clr_start", V_BUSY | V_EN);
    clearEngine(3, 1'b1);

    // Back in RUN: no second clear started by the ignored request.
    applyStimulus("run_idle0", V_NONE);
    applyStimulus("run_idle1", V_NONE);

    // Last winner was EV and survives the clear, so HOST wins first now.
    ev_req = 1'b1; ev_addr = 4'd6; ev_wdata = 32'h6666_6666;
    h_req = 1'b1; h_we = 1'b1; h_addr = 4'd4; h_wdata = 32'h4444_4444;
    h_wmask = 4'hF;
    applyStimulus("rr_post_h", V_H);
    applyStimulus("rr_post_ev", V_EV);

    // Host read followed by reset: the returning rvalid is suppressed.
    ev_req = 1'b0; h_we = 1'b0; h_addr = 4'd3;
    applyStimulus("h_rd_pre_rst", V_H);
    h_req = 1'b0; rst = 1'b1;
    applyStimulus("rst_run", V_BUSY);
    rst = 1'b0;
    applyStimulus("rst_run_start", V_BUSY | V_EN);

    // Reset in the middle of CLR_BUSY restarts the clear.
    rs_ce_a = 1'b1; rs_ce_b = 1'b1;
    applyStimulus("busy_pre_rst", V_BUSY);
    rst = 1'b1; rs_ce_a = 1'b0; rs_ce_b = 1'b0;
    applyStimulus("rst_busy", V_BUSY);
    rst = 1'b0;
    applyStimulus("rst_busy_start", V_BUSY | V_EN);
    clearEngine(2, 1'b0);
    applyStimulus("final_idle", V_NONE);

    total++;
    if (exp_q.size() != 0 || hq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: leftover exp=%0d h=%0d rd=%0d want=0",
               exp_q.size(), hq.size(), rq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
